// File: rtl/alu_seq_if.sv
// Request/result bundle for the sequential ALU.
// The control unit drives the request; the ALU returns results and status.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       gin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] hi;
    logic             zout;
    logic             n;
    logic             v;
    logic             busy;
    logic             done;

    modport master (
        output start, gin, a, b,
        input  sum, hi, zout, n, v, busy, done
    );

    modport slave (
        input  start, gin, a, b,
        output sum, hi, zout, n, v, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Registered MIPS ALU: single-cycle ALU ops plus multi-cycle
// shift-add multiply and restoring unsigned divide.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHAMT = 2,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zout_q, zout_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] add_r, sub_r;
    logic             add_ov, sub_ov;
    logic [WIDTH:0]   mul_s, div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] it_acc, it_lo;

    always_comb begin
        add_r  = bus.a + bus.b;
        sub_r  = bus.a - bus.b;
        add_ov = (bus.a[MSB] == bus.b[MSB]) && (add_r[MSB] != bus.a[MSB]);
        sub_ov = (bus.a[MSB] != bus.b[MSB]) && (sub_r[MSB] != bus.a[MSB]);
    end

    // One iteration: acc is product-high / remainder, lo is multiplier / quotient
    always_comb begin
        mul_s  = {1'b0, acc_q} + ({1'b0, m_q} & {(WIDTH+1){lo_q[0]}});
        div_sh = {acc_q, lo_q[MSB]};
        div_ok = div_sh >= {1'b0, m_q};
        if (div_q) begin
            it_acc = div_ok ? div_sh[MSB:0] - m_q : div_sh[MSB:0];
            it_lo  = {lo_q[MSB-1:0], div_ok};
        end else begin
            it_acc = mul_s[WIDTH:1];
            it_lo  = {mul_s[0], lo_q[MSB:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        m_d     = m_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        zout_d  = zout_q;
        n_d     = n_q;
        v_d     = v_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.gin[2:1] == 2'b10) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(WIDTH);
                    div_d   = bus.gin[0];
                    m_d     = bus.b;
                    lo_d    = bus.a;
                    acc_d   = '0;
                end else if (bus.start) begin
                    done_d = 1'b1;
                    hi_d   = '0;
                    v_d    = 1'b0;
                    unique case (bus.gin)
                        OP_AND: sum_d = bus.a & bus.b;
                        OP_OR:  sum_d = bus.a | bus.b;
                        OP_ADD: begin
                            sum_d = add_r;
                            v_d   = add_ov;
                        end
                        OP_SHL: sum_d = bus.a << SHAMT;
                        OP_SUB: begin
                            sum_d = sub_r;
                            v_d   = sub_ov;
                        end
                        OP_SLT: sum_d = {{MSB{1'b0}}, sub_r[MSB] ^ sub_ov};
                        default: sum_d = '0;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = it_acc;
                lo_d  = it_lo;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    sum_d   = it_lo;
                    hi_d    = it_acc;
                    v_d     = div_q ? (m_q == '0) : (it_acc != '0);
                end
            end
            default: state_d = IDLE;
        endcase
        if (done_d) begin
            zout_d = (sum_d == '0);
            n_d    = sum_d[MSB];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            sum_q   <= '0;
            hi_q    <= '0;
            zout_q  <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            zout_q  <= zout_d;
            n_q     <= n_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.hi   = hi_q;
    assign bus.zout = zout_q;
    assign bus.n    = n_q;
    assign bus.v    = v_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule
